// File: rtl/alu_flag_stage_if.sv
// Handshake and payload bundle for alu_flag_stage.
// The master side is the upstream ALU plus the writeback consumer; the slave side is the stage.
interface alu_flag_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        in_carry;
    logic [1:0]  in_size;
    logic        in_setflags;
    logic [4:0]  in_dest;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_dest;
    logic        out_zero;
    logic        out_carry;
    logic        out_negative;

    modport master (
        output in_valid, in_result, in_carry, in_size, in_setflags, in_dest, out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_zero, out_carry, out_negative
    );

    modport slave (
        input  in_valid, in_result, in_carry, in_size, in_setflags, in_dest, out_ready,
        output in_ready, out_valid, out_result, out_dest, out_zero, out_carry, out_negative
    );
endinterface

// File: rtl/alu_flag_stage.sv
// ALU flag stage: masks the raw ALU result to the operand size, derives zero/negative flags
// at capture and hands the transaction to writeback through a registered pipeline stage.
// Architectural flags {negative, carry, zero} update when a setflags transaction leaves.
// Build option: define ALU_FLAG_SKID_EN for a 2-entry skid buffer with a registered in_ready;
// otherwise the stage is a single register with a combinational in_ready.
module alu_flag_stage (
    input  logic             clk,
    input  logic             rst,
    alu_flag_stage_if.slave  bus,
    output logic [2:0]       flags_q
);

    // Operand size encodings
    localparam logic [1:0] Bits8  = 2'd0;
    localparam logic [1:0] Bits16 = 2'd1;
    localparam logic [1:0] Bits32 = 2'd2;
    localparam logic [1:0] Bits64 = 2'd3;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  dest;
        logic        zero;
        logic        carry;
        logic        negative;
        logic        setflags;
    } entry_t;

    entry_t      w_entry;
    logic [63:0] w_masked;
    logic        w_push;
    logic        w_pop;
    logic        w_in_ready;

    entry_t      r_head;
    logic        r_head_valid;
    logic [2:0]  r_flags;

    // Size masking and flag derivation for the incoming result
    always_comb begin
        w_masked = bus.in_result;
        w_entry  = '0;
        unique case (bus.in_size)
            Bits8:  w_masked = {56'd0, bus.in_result[7:0]};
            Bits16: w_masked = {48'd0, bus.in_result[15:0]};
            Bits32: w_masked = {32'd0, bus.in_result[31:0]};
            Bits64: w_masked = bus.in_result;
        endcase
        w_entry.result   = w_masked;
        w_entry.dest     = bus.in_dest;
        w_entry.zero     = (w_masked == 64'd0);
        w_entry.carry    = bus.in_carry;
        w_entry.setflags = bus.in_setflags;
        unique case (bus.in_size)
            Bits8:  w_entry.negative = w_masked[7];
            Bits16: w_entry.negative = w_masked[15];
            Bits32: w_entry.negative = w_masked[31];
            Bits64: w_entry.negative = w_masked[63];
        endcase
    end

    assign w_push = bus.in_valid && w_in_ready;
    assign w_pop  = r_head_valid && bus.out_ready;

`ifdef ALU_FLAG_SKID_EN
    entry_t r_skid;
    logic   r_skid_valid;
    logic   r_in_ready;
    entry_t w_head_d;
    entry_t w_skid_d;
    logic   w_head_valid_d;
    logic   w_skid_valid_d;

    assign w_in_ready = r_in_ready;

    // Skid next state: pop promotes the skid entry, a push fills the first free slot
    always_comb begin
        w_head_d       = r_head;
        w_skid_d       = r_skid;
        w_head_valid_d = r_head_valid;
        w_skid_valid_d = r_skid_valid;
        if (w_pop) begin
            if (r_skid_valid) begin
                w_head_d       = r_skid;
                w_skid_valid_d = 1'b0;
            end else begin
                w_head_valid_d = 1'b0;
            end
        end
        if (w_push) begin
            if (!w_head_valid_d) begin
                w_head_d       = w_entry;
                w_head_valid_d = 1'b1;
            end else begin
                w_skid_d       = w_entry;
                w_skid_valid_d = 1'b1;
            end
        end
    end

    // Entry registers; in_ready registered from the next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= '0;
            r_skid       <= '0;
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_head       <= w_head_d;
            r_skid       <= w_skid_d;
            r_head_valid <= w_head_valid_d;
            r_skid_valid <= w_skid_valid_d;
            r_in_ready   <= !(w_head_valid_d && w_skid_valid_d);
        end
    end
`else
    // Single entry: accept when empty or when the held entry leaves this cycle
    assign w_in_ready = !r_head_valid || bus.out_ready;

    // Entry register; payload is held after a pop and simply marked invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= '0;
            r_head_valid <= 1'b0;
        end else if (w_push) begin
            r_head       <= w_entry;
            r_head_valid <= 1'b1;
        end else if (w_pop) begin
            r_head_valid <= 1'b0;
        end
    end
`endif

    // Architectural flags follow departing setflags transactions
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else if (w_pop && r_head.setflags) begin
            r_flags <= {r_head.negative, r_head.carry, r_head.zero};
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_head_valid;
    assign bus.out_result   = r_head.result;
    assign bus.out_dest     = r_head.dest;
    assign bus.out_zero     = r_head.zero;
    assign bus.out_carry    = r_head.carry;
    assign bus.out_negative = r_head.negative;
    assign flags_q          = r_flags;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Scoreboard bench for alu_flag_stage: the monitor queues each accepted vector and compares
// the head of the queue against the DUT whenever out_valid is high.
module tb_alu_flag_stage;

`ifdef ALU_FLAG_SKID_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] flags_q;

    always #5 clk = ~clk;

    alu_flag_stage_if bus ();

    alu_flag_stage dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .flags_q (flags_q)
    );

    typedef struct {
        logic [63:0] res;
        logic [1:0]  size;
        logic        carry;
        logic        setf;
        logic [4:0]  dest;
        logic [63:0] exp_res;
        logic        exp_z;
        logic        exp_n;
    } vec_t;

    vec_t       vecs [10];
    int         q [$];
    int         drv_idx;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_out    = 0;
    logic       mon_en;
    logic [2:0] exp_flags;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        drv_idx         = i;
        bus.in_valid    = 1'b1;
        bus.in_result   = vecs[i].res;
        bus.in_size     = vecs[i].size;
        bus.in_carry    = vecs[i].carry;
        bus.in_setflags = vecs[i].setf;
        bus.in_dest     = vecs[i].dest;
    endtask

    task automatic send(input int i);
        drive(i);
        check("in_ready before send", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            check("flags_q", 64'(flags_q), 64'(exp_flags));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL stray out_valid: got 1, want 0 (no transaction pending)");
                end else begin
                    int k;
                    k = q[0];
                    check("out_result", bus.out_result, vecs[k].exp_res);
                    check("out_dest", 64'(bus.out_dest), 64'(vecs[k].dest));
                    check("out_zero", 64'(bus.out_zero), 64'(vecs[k].exp_z));
                    check("out_carry", 64'(bus.out_carry), 64'(vecs[k].carry));
                    check("out_negative", 64'(bus.out_negative), 64'(vecs[k].exp_n));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                        if (vecs[k].setf) exp_flags = {vecs[k].exp_n, vecs[k].carry, vecs[k].exp_z};
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(drv_idx);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int acc;
        int idx;
        vecs[0] = '{64'h1234_5678_9ABC_DE80, 2'd0, 1'b1, 1'b1, 5'd1,  64'h80,                1'b0, 1'b1};
        vecs[1] = '{64'h0000_0000_FFFF_0000, 2'd1, 1'b0, 1'b0, 5'd2,  64'h0,                 1'b1, 1'b0};
        vecs[2] = '{64'h8000_0000_0000_0000, 2'd3, 1'b0, 1'b1, 5'd3,  64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h0000_0001_7FFF_FFFF, 2'd2, 1'b1, 1'b1, 5'd4,  64'h7FFF_FFFF,         1'b0, 1'b0};
        vecs[4] = '{64'h0000_0000_0000_FF00, 2'd0, 1'b0, 1'b1, 5'd5,  64'h0,                 1'b1, 1'b0};
        vecs[5] = '{64'h0000_0000_ABCD_8001, 2'd1, 1'b0, 1'b0, 5'd6,  64'h8001,              1'b0, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_8000_0000, 2'd2, 1'b1, 1'b0, 5'd7,  64'h8000_0000,         1'b0, 1'b1};
        vecs[7] = '{64'h0000_0000_0000_0000, 2'd3, 1'b1, 1'b1, 5'd8,  64'h0,                 1'b1, 1'b0};
        vecs[8] = '{64'h0000_0000_0000_007F, 2'd0, 1'b0, 1'b1, 5'd9,  64'h7F,                1'b0, 1'b0};
        vecs[9] = '{64'h0000_0001_0000_0000, 2'd2, 1'b0, 1'b0, 5'd10, 64'h0,                 1'b1, 1'b0};

        rst             = 1'b1;
        mon_en          = 1'b0;
        exp_flags       = 3'b000;
        drv_idx         = 0;
        bus.in_valid    = 1'b0;
        bus.in_result   = '0;
        bus.in_size     = '0;
        bus.in_carry    = 1'b0;
        bus.in_setflags = 1'b0;
        bus.in_dest     = '0;
        bus.out_ready   = 1'b0;

        // Reset state
        repeat (2) tick();
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_result", bus.out_result, 64'd0);
        check("reset out_dest", 64'(bus.out_dest), 64'd0);
        check("reset out_zero", 64'(bus.out_zero), 64'd0);
        check("reset out_carry", 64'(bus.out_carry), 64'd0);
        check("reset out_negative", 64'(bus.out_negative), 64'd0);
        check("reset flags_q", 64'(flags_q), 64'd0);
        rst = 1'b0;
        tick();
        check("in_ready after reset", 64'(bus.in_ready), 64'd1);
        mon_en = 1'b1;

        // Single transactions: BITS_8 negative with flags, then BITS_16 zero without flags
        bus.out_ready = 1'b1;
        send(0);
        tick();
        check("flags after BITS_8 vector", 64'(flags_q), 64'h6);
        send(1);
        repeat (2) tick();
        check("flags held with setflags=0", 64'(flags_q), 64'h6);

        // Back-to-back: 8 transactions, one per cycle
        n0 = n_out;
        for (int k = 2; k < 10; k++) begin
            drive(k);
            check("in_ready back-to-back", 64'(bus.in_ready), 64'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        check("b2b outputs after 8 cycles", 64'(n_out - n0), 64'd7);
        tick();
        check("b2b outputs total", 64'(n_out - n0), 64'd8);

        // Output stall for 3 cycles with in_valid held
        bus.out_ready = 1'b0;
        acc = 0;
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            drive(idx);
            if (bus.in_ready) begin
                acc++;
                idx++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        check("accepts during stall", 64'(acc), 64'(Cap));
        check("in_ready when full", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && (q.size() != 0 || bus.out_valid); c++) tick();
        check("stall drain queue empty", 64'(q.size()), 64'd0);
        check("flags after stall drain", 64'(flags_q), 64'h6);

        // Reset with entries held
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(3 + c);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        check("held before reset", 64'(bus.out_valid), 64'd1);
        mon_en = 1'b0;
        q.delete();
        rst = 1'b1;
        tick();
        check("out_valid after mid reset", 64'(bus.out_valid), 64'd0);
        check("flags_q after mid reset", 64'(flags_q), 64'd0);
        rst           = 1'b0;
        exp_flags     = 3'b000;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("no stale out_valid", 64'(bus.out_valid), 64'd0);
        end
        mon_en = 1'b1;

        // BITS_64 MSB case after reset
        send(2);
        repeat (2) tick();
        check("flags after BITS_64 vector", 64'(flags_q), 64'h4);
        check("final queue empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_flag_stage.md
ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  upstream ALU result valid.
REQ-004 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-005 SHALL have port in_result  input  64  raw ALU result (ulong_t).
REQ-006 SHALL have port in_carry  input  1  raw ALU carry.
REQ-007 SHALL have port in_size  input  2  operand size (sizeFlags_t: BITS_8, BITS_16, BITS_32, BITS_64).
REQ-008 SHALL have port in_setflags  input  1  transaction updates the architectural flags.
REQ-009 SHALL have port in_dest  input  5  destination register index.
REQ-010 SHALL have port out_valid  output  1  writeback transaction valid.
REQ-011 SHALL have port out_ready  input  1  writeback accepts transaction.
REQ-012 SHALL have port out_result  output  64  result zero-extended from in_size.
REQ-013 SHALL have ports out_dest (5), out_zero (1), out_carry (1), out_negative (1), all outputs, belonging to the transaction on out_result.
REQ-014 SHALL have port flags_q  output  3  architectural flags {negative, carry, zero}.

Function
REQ-015 Input handshake SHALL complete when in_valid && in_ready; output handshake SHALL complete when out_valid && out_ready.
REQ-016 out_result SHALL be in_result with bits above the size width (8/16/32/64) forced to 0.
REQ-017 out_zero SHALL be 1 exactly when the masked result equals 0.
REQ-018 out_negative SHALL equal the masked result's MSB (bit 7/15/31/63 per size).
REQ-019 out_carry SHALL equal in_carry unmodified.
REQ-020 Flag computation SHALL occur at capture; outputs SHALL come from registers, with no combinational path from in_* to out_*.
REQ-021 Latency SHALL be 1 cycle: data accepted in cycle N SHALL appear on out_* in cycle N+1.
REQ-022 Transactions SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-023 out_* payload SHALL stay stable while out_valid && !out_ready.
REQ-024 flags_q SHALL load {out_negative, out_carry, out_zero} on the cycle after an output handshake whose transaction had in_setflags=1.
REQ-025 flags_q SHALL hold its value otherwise, including when setflags=0.
REQ-026 With simultaneous input and output handshakes, the stage SHALL drain the head, capture the new entry, and sustain 1 transaction/cycle.
REQ-027 When full, the stage SHALL deassert in_ready and SHALL ignore in_valid.

Reset
REQ-028 While rst=1, the stage SHALL clear all entries.
REQ-029 While rst=1, outputs SHALL be: out_valid=0, out_result=0, out_dest=0, out_zero=0, out_carry=0, out_negative=0, flags_q=3'b000.
REQ-030 Reset asserted mid-transfer SHALL discard all held transactions with no flag update.
REQ-031 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-032 Macro ALU_FLAG_SKID_EN defined: the stage SHALL be a 2-entry skid buffer.
REQ-033 With ALU_FLAG_SKID_EN: in_ready SHALL be a register output, equal to 1 when fewer than 2 entries are held.
REQ-034 With ALU_FLAG_SKID_EN: a second entry SHALL be captured when the output stalls.
REQ-035 Macro ALU_FLAG_SKID_EN undefined: the stage SHALL be a 1-entry register with in_ready = !out_valid || out_ready (combinational).
REQ-036 Function and latency SHALL be identical in both builds.

Verification
REQ-037 BITS_8, in_result=64'h1234_5678_9ABC_DE80, carry=1, setflags=1, out_ready=1 -> next cycle out_result=64'h80, negative=1, zero=0, carry=1; flags_q=3'b110 one cycle later.
REQ-038 BITS_16, in_result=64'hFFFF_0000 -> out_result=0, zero=1, negative=0; with setflags=0, flags_q unchanged.
REQ-039 Back-to-back 8 transactions with out_ready=1 -> 8 outputs on consecutive cycles in order, in_ready constantly 1.
REQ-040 out_ready=0 for 3 cycles, in_valid=1 -> out payload stable; in_ready drops after 2 accepts (SKID_EN) or 1 accept (no SKID_EN); all entries later emerge in order.
REQ-041 rst pulsed while 2 entries held -> out_valid=0 and flags_q=0 next cycle; no stale transaction emerges afterwards.
REQ-042 BITS_64, in_result=64'h8000_0000_0000_0000 -> out_result unchanged, negative=1, zero=0.
